// File: rtl/iob_ext_mem_arbiter_pkg.sv
// Shared definitions for the external-memory arbiter.
//   state_t   : arbiter FSM state encoding
//   idx_width : width of a master index for a given master count (min 1)
package iob_ext_mem_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GRANT   = 2'd1,
    ST_WAIT_RD = 2'd2
  } state_t;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/iob_rr_prio.sv
// Round-robin priority selector.
// Searches the request vector starting one position after the last winner,
// wrapping modulo N, and reports the first requester found.
//   req_i      in  N       request vector
//   last_i     in  IDX_W   index of the previous winner
//   winner_o   out N       one-hot winner (zero when no request)
//   win_idx_o  out IDX_W   binary index of the winner
//   any_o      out 1       at least one request present
module iob_rr_prio #(
  parameter int N     = 2,
  parameter int IDX_W = 1
) (
  input  logic [N-1:0]     req_i,
  input  logic [IDX_W-1:0] last_i,
  output logic [N-1:0]     winner_o,
  output logic [IDX_W-1:0] win_idx_o,
  output logic             any_o
);

  always_comb begin
    int   cand;
    logic found;
    winner_o  = '0;
    win_idx_o = '0;
    found     = 1'b0;
    cand      = 0;
    for (int i = 1; i <= N; i++) begin
      cand = (int'(last_i) + i) % N;
      if (!found && req_i[cand[IDX_W-1:0]]) begin
        found                         = 1'b1;
        winner_o[cand[IDX_W-1:0]]     = 1'b1;
        win_idx_o                     = cand[IDX_W-1:0];
      end
    end
    any_o = found;
  end

endmodule

// File: rtl/iob_ext_mem_arbiter.sv
// Round-robin arbiter sharing one external memory port among N_MASTERS
// requesters. One transaction is outstanding at a time.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_IDLE    | no owner; pick round-robin winner when any request is valid
// ST_GRANT   | owner's request routed to the memory port until accepted
// ST_WAIT_RD | read accepted; waiting (unbounded) for s_rvalid_i
//
// Ports:
//   clk_i, rst_i, cke_i                 clock, sync active-high reset, clock enable
//   m_avalid_i/m_addr_i/m_wdata_i/m_wstrb_i  per-master requests (slice i = master i)
//   m_rdata_o, m_rvalid_o, m_ready_o    per-master responses (rdata broadcast)
//   s_avalid_o/s_addr_o/s_wdata_o/s_wstrb_o  shared memory request
//   s_rdata_i, s_rvalid_i, s_ready_i    shared memory response
//   grant_o, busy_o                     current owner (one-hot), FSM not idle
module iob_ext_mem_arbiter
  import iob_ext_mem_arbiter_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int N_MASTERS = 2
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic                              cke_i,
  input  logic [N_MASTERS-1:0]              m_avalid_i,
  input  logic [N_MASTERS*ADDR_W-1:0]       m_addr_i,
  input  logic [N_MASTERS*DATA_W-1:0]       m_wdata_i,
  input  logic [N_MASTERS*(DATA_W/8)-1:0]   m_wstrb_i,
  output logic [DATA_W-1:0]                 m_rdata_o,
  output logic [N_MASTERS-1:0]              m_rvalid_o,
  output logic [N_MASTERS-1:0]              m_ready_o,
  output logic                              s_avalid_o,
  output logic [ADDR_W-1:0]                 s_addr_o,
  output logic [DATA_W-1:0]                 s_wdata_o,
  output logic [DATA_W/8-1:0]               s_wstrb_o,
  input  logic [DATA_W-1:0]                 s_rdata_i,
  input  logic                              s_rvalid_i,
  input  logic                              s_ready_i,
  output logic [N_MASTERS-1:0]              grant_o,
  output logic                              busy_o
);

  localparam int IDX_W  = idx_width(N_MASTERS);
  localparam int STRB_W = DATA_W / 8;

  state_t                 state;
  logic [IDX_W-1:0]       grant_idx;
  logic [IDX_W-1:0]       last_grant;
  logic [N_MASTERS-1:0]   grant_q;

  logic [N_MASTERS-1:0]   rr_winner;
  logic [IDX_W-1:0]       rr_idx;
  logic                   rr_any;

  logic                   sel_avalid;
  logic [ADDR_W-1:0]      sel_addr;
  logic [DATA_W-1:0]      sel_wdata;
  logic [STRB_W-1:0]      sel_wstrb;

  iob_rr_prio #(
    .N     (N_MASTERS),
    .IDX_W (IDX_W)
  ) u_rr_prio (
    .req_i     (m_avalid_i),
    .last_i    (last_grant),
    .winner_o  (rr_winner),
    .win_idx_o (rr_idx),
    .any_o     (rr_any)
  );

  // Request fields of the owner, selected by the registered grant index.
  always_comb begin
    sel_avalid = m_avalid_i[grant_idx];
    sel_addr   = m_addr_i[grant_idx*ADDR_W +: ADDR_W];
    sel_wdata  = m_wdata_i[grant_idx*DATA_W +: DATA_W];
    sel_wstrb  = m_wstrb_i[grant_idx*STRB_W +: STRB_W];
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state      <= ST_IDLE;
      grant_idx  <= '0;
      grant_q    <= '0;
      last_grant <= IDX_W'(N_MASTERS - 1);
    end else if (cke_i) begin
      case (state)
        ST_IDLE: begin
          if (rr_any) begin
            grant_idx <= rr_idx;
            grant_q   <= rr_winner;
            state     <= ST_GRANT;
          end
        end
        ST_GRANT: begin
          if (!sel_avalid) begin
            // owner withdrew before acceptance: abandon without a transfer
            state      <= ST_IDLE;
            grant_q    <= '0;
            last_grant <= grant_idx;
          end else if (s_ready_i) begin
            if (sel_wstrb != '0) begin
              state      <= ST_IDLE;
              grant_q    <= '0;
              last_grant <= grant_idx;
            end else begin
              state <= ST_WAIT_RD;
            end
          end
        end
        ST_WAIT_RD: begin
          if (s_rvalid_i) begin
            state      <= ST_IDLE;
            grant_q    <= '0;
            last_grant <= grant_idx;
          end
        end
        default: begin
          state   <= ST_IDLE;
          grant_q <= '0;
        end
      endcase
    end
  end

  // Memory-port routing; everything is forced to zero outside the owning state
  // so stray slave responses never reach a master.
  always_comb begin
    s_avalid_o = 1'b0;
    s_addr_o   = '0;
    s_wdata_o  = '0;
    s_wstrb_o  = '0;
    m_ready_o  = '0;
    m_rvalid_o = '0;
    case (state)
      ST_GRANT: begin
        s_avalid_o           = sel_avalid;
        s_addr_o             = sel_addr;
        s_wdata_o            = sel_wdata;
        s_wstrb_o            = sel_wstrb;
        m_ready_o[grant_idx] = s_ready_i;
      end
      ST_WAIT_RD: begin
        m_rvalid_o[grant_idx] = s_rvalid_i;
      end
      default: begin
      end
    endcase
  end

  assign m_rdata_o = s_rdata_i;
  assign grant_o   = grant_q;
  assign busy_o    = (state != ST_IDLE);

endmodule

// File: tb/tb_iob_ext_mem_arbiter.sv
// Directed bench for iob_ext_mem_arbiter with two 32-bit masters.
module tb_iob_ext_mem_arbiter;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        cke_i;
  logic [1:0]  m_avalid_i;
  logic [31:0] addr0, addr1, wdata0, wdata1;
  logic [3:0]  wstrb0, wstrb1;
  logic [63:0] m_addr_i, m_wdata_i;
  logic [7:0]  m_wstrb_i;
  logic [31:0] m_rdata_o;
  logic [1:0]  m_rvalid_o, m_ready_o;
  logic        s_avalid_o;
  logic [31:0] s_addr_o, s_wdata_o;
  logic [3:0]  s_wstrb_o;
  logic [31:0] s_rdata_i;
  logic        s_rvalid_i, s_ready_i;
  logic [1:0]  grant_o;
  logic        busy_o;

  int vectors     = 0;
  int miscompares = 0;

  assign m_addr_i  = {addr1, addr0};
  assign m_wdata_i = {wdata1, wdata0};
  assign m_wstrb_i = {wstrb1, wstrb0};

  iob_ext_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .N_MASTERS(2)) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .cke_i      (cke_i),
    .m_avalid_i (m_avalid_i),
    .m_addr_i   (m_addr_i),
    .m_wdata_i  (m_wdata_i),
    .m_wstrb_i  (m_wstrb_i),
    .m_rdata_o  (m_rdata_o),
    .m_rvalid_o (m_rvalid_o),
    .m_ready_o  (m_ready_o),
    .s_avalid_o (s_avalid_o),
    .s_addr_o   (s_addr_o),
    .s_wdata_o  (s_wdata_o),
    .s_wstrb_o  (s_wstrb_o),
    .s_rdata_i  (s_rdata_i),
    .s_rvalid_i (s_rvalid_i),
    .s_ready_i  (s_ready_i),
    .grant_o    (grant_o),
    .busy_o     (busy_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    rst_i = 1'b1; cke_i = 1'b1; m_avalid_i = 2'b00;
    addr0 = 32'h10; addr1 = 32'h20; wdata0 = 32'h0; wdata1 = 32'h0;
    wstrb0 = 4'h0; wstrb1 = 4'h0;
    s_rdata_i = 32'h1234; s_rvalid_i = 1'b1; s_ready_i = 1'b0;
    cyc(); cyc();

    // Reset state, stray rvalid ignored, rdata passthrough
    chk("rst_busy",   busy_o, 0);
    chk("rst_grant",  grant_o, 0);
    chk("rst_savalid", s_avalid_o, 0);
    chk("rst_mready", m_ready_o, 0);
    chk("rst_mrvalid", m_rvalid_o, 0);
    chk("rst_rdata",  m_rdata_o, 32'h1234);
    s_rvalid_i = 1'b0;

    // Both masters read after reset: master 0 first, then master 1
    rst_i = 1'b0; m_avalid_i = 2'b11; s_ready_i = 1'b1;
    #1 chk("a_idle_busy", busy_o, 0);
    cyc();
    chk("a_g0_grant", grant_o, 2'b01);
    chk("a_g0_addr",  s_addr_o, 32'h10);
    chk("a_g0_sav",   s_avalid_o, 1);
    chk("a_g0_ready", m_ready_o, 2'b01);
    cyc();
    m_avalid_i = 2'b10;
    #1 chk("a_wr0_sav", s_avalid_o, 0);
    chk("a_wr0_busy", busy_o, 1);
    chk("a_wr0_rv_lo", m_rvalid_o, 2'b00);
    s_rvalid_i = 1'b1; s_rdata_i = 32'hA0;
    #1 chk("a_wr0_rv", m_rvalid_o, 2'b01);
    chk("a_wr0_data", m_rdata_o, 32'hA0);
    cyc();
    s_rvalid_i = 1'b0;
    #1 chk("a_idle_grant", grant_o, 0);
    chk("a_idle_busy2", busy_o, 0);
    cyc();
    chk("a_g1_grant", grant_o, 2'b10);
    chk("a_g1_addr",  s_addr_o, 32'h20);
    chk("a_g1_ready", m_ready_o, 2'b10);
    cyc();
    m_avalid_i = 2'b00;
    s_rvalid_i = 1'b1;
    #1 chk("a_wr1_rv", m_rvalid_o, 2'b10);
    cyc();
    s_rvalid_i = 1'b0;

    // Master 1 write; stray rvalid in IDLE/GRANT is ignored
    m_avalid_i = 2'b10; addr1 = 32'h100; wdata1 = 32'hCAFEF00D; wstrb1 = 4'hF;
    s_ready_i = 1'b1; s_rvalid_i = 1'b1;
    #1 chk("b_idle_sav", s_avalid_o, 0);
    chk("b_idle_rv", m_rvalid_o, 0);
    cyc();
    chk("b_sav",   s_avalid_o, 1);
    chk("b_addr",  s_addr_o, 32'h100);
    chk("b_wdata", s_wdata_o, 32'hCAFEF00D);
    chk("b_wstrb", s_wstrb_o, 4'hF);
    chk("b_ready", m_ready_o, 2'b10);
    chk("b_rv",    m_rvalid_o, 0);
    cyc();
    m_avalid_i = 2'b00; s_rvalid_i = 1'b0;
    chk("b_done_busy", busy_o, 0);
    chk("b_done_grant", grant_o, 0);

    // Master 0 read with 5-cycle response delay
    m_avalid_i = 2'b01; addr0 = 32'h40; wstrb0 = 4'h0; s_ready_i = 1'b1;
    cyc();
    chk("c_grant", grant_o, 2'b01);
    cyc();
    m_avalid_i = 2'b00; s_ready_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("c_wait_busy", busy_o, 1);
      chk("c_wait_rv", m_rvalid_o, 0);
      cyc();
    end
    s_rvalid_i = 1'b1; s_rdata_i = 32'hDEADBEEF;
    #1 chk("c_rv", m_rvalid_o, 2'b01);
    chk("c_data", m_rdata_o, 32'hDEADBEEF);
    chk("c_busy", busy_o, 1);
    cyc();
    s_rvalid_i = 1'b0;
    #1 chk("c_done_busy", busy_o, 0);
    chk("c_done_rv", m_rvalid_o, 0);

    // Reset during WAIT_RD, late response discarded, master 0 wins next
    m_avalid_i = 2'b10; wstrb1 = 4'h0; s_ready_i = 1'b1;
    cyc();
    chk("e_grant", grant_o, 2'b10);
    cyc();
    m_avalid_i = 2'b00;
    chk("e_wait_busy", busy_o, 1);
    rst_i = 1'b1;
    cyc();
    rst_i = 1'b0; s_rvalid_i = 1'b1;
    #1 chk("e_rv_drop", m_rvalid_o, 0);
    chk("e_busy", busy_o, 0);
    chk("e_grant0", grant_o, 0);
    cyc();
    s_rvalid_i = 1'b0;
    chk("e_still_idle", busy_o, 0);

    // Both masters writing continuously: strict alternation from master 0
    wstrb0 = 4'hF; wstrb1 = 4'hF; m_avalid_i = 2'b11; s_ready_i = 1'b1;
    cyc();
    for (int k = 0; k < 20; k++) begin
      chk("d_grant", grant_o, (k % 2 == 0) ? 2'b01 : 2'b10);
      chk("d_addr",  s_addr_o, (k % 2 == 0) ? 32'h40 : 32'h100);
      cyc();
      chk("d_idle", busy_o, 0);
      if (k == 19) m_avalid_i = 2'b00;
      else cyc();
    end

    // Clock enable low in GRANT with s_ready low: everything holds
    m_avalid_i = 2'b01; wstrb0 = 4'h0; s_ready_i = 1'b0;
    cyc();
    chk("f_grant", grant_o, 2'b01);
    cke_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("f_hold_grant", grant_o, 2'b01);
      chk("f_hold_busy", busy_o, 1);
    end
    cke_i = 1'b1; s_ready_i = 1'b1;
    #1 chk("f_ready", m_ready_o, 2'b01);
    cyc();
    m_avalid_i = 2'b00; s_ready_i = 1'b0;
    chk("f_wait_sav", s_avalid_o, 0);
    s_rvalid_i = 1'b1; s_rdata_i = 32'h5A5A5A5A;
    #1 chk("f_rv", m_rvalid_o, 2'b01);
    chk("f_data", m_rdata_o, 32'h5A5A5A5A);
    cyc();
    s_rvalid_i = 1'b0;

    // Clock enable low in IDLE blocks arbitration; then abort by master 1
    m_avalid_i = 2'b11; wstrb0 = 4'hF; wstrb1 = 4'hF; cke_i = 1'b0;
    cyc(); cyc();
    chk("g_cke_idle", busy_o, 0);
    cke_i = 1'b1;
    cyc();
    chk("g_grant1", grant_o, 2'b10);
    m_avalid_i = 2'b01;
    #1 chk("g_abort_sav", s_avalid_o, 0);
    cyc();
    chk("g_abort_idle", busy_o, 0);
    chk("g_abort_grant", grant_o, 0);
    cyc();
    chk("g_next_grant0", grant_o, 2'b01);
    s_ready_i = 1'b1;
    cyc();
    m_avalid_i = 2'b00;
    chk("g_end_idle", busy_o, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/iob_ext_mem_arbiter.md
IOB_EXT_MEM_ARBITER -- requirements
Module: iob_ext_mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 32, address width of every port.
REQ-002 Parameter DATA_W, default 32, data width; strobe width DATA_W/8.
REQ-003 Parameter N_MASTERS, default 2, number of requesters; legal range 2..8.
REQ-004 The block SHALL use one clock and a synchronous, active-high reset: clk_i  in  1  clock; rst_i  in  1  synchronous active-high reset.
REQ-005 cke_i  in  1  clock enable; when low, all registers hold.
REQ-006 m_avalid_i  in  N_MASTERS  per-master request valid.
REQ-007 m_addr_i  in  N_MASTERS*ADDR_W  per-master address; master i at slice i.
REQ-008 m_wdata_i  in  N_MASTERS*DATA_W  per-master write data.
REQ-009 m_wstrb_i  in  N_MASTERS*DATA_W/8  per-master strobe; all-zero means read.
REQ-010 m_rdata_o  out  DATA_W  read data, broadcast to all masters.
REQ-011 m_rvalid_o  out  N_MASTERS  per-master read-data valid.
REQ-012 m_ready_o  out  N_MASTERS  per-master request accepted.
REQ-013 s_avalid_o, s_addr_o, s_wdata_o, s_wstrb_o  out  1/ADDR_W/DATA_W/DATA_W/8  shared memory-port request.
REQ-014 s_rdata_i, s_rvalid_i, s_ready_i  in  DATA_W/1/1  shared memory-port response.
REQ-015 grant_o  out  N_MASTERS  one-hot current owner, zero when idle; busy_o  out  1  state != IDLE.

Function
REQ-016 FSM states SHALL be IDLE, GRANT, WAIT_RD.
REQ-017 IDLE: if any m_avalid_i bit set, register round-robin winner into grant, go GRANT next cycle; else stay.
REQ-018 Round-robin: search starts at last_grant+1 modulo N_MASTERS; last_grant updates on every return to IDLE from GRANT/WAIT_RD.
REQ-019 GRANT: s_avalid/addr/wdata/wstrb SHALL equal the granted master's signals; non-granted masters see m_ready_o=0.
REQ-020 GRANT: m_ready_o[g] = s_ready_i; other bits 0.
REQ-021 GRANT, s_avalid_o & s_ready_i, wstrb != 0: write complete, go IDLE.
REQ-022 GRANT, s_avalid_o & s_ready_i, wstrb == 0: go WAIT_RD.
REQ-023 GRANT, granted master drops m_avalid_i before acceptance: go IDLE, no slave transaction.
REQ-024 WAIT_RD: s_avalid_o=0; on s_rvalid_i, m_rvalid_o[g]=1 same cycle (combinational), go IDLE.
REQ-025 s_rvalid_i outside WAIT_RD SHALL be ignored (no m_rvalid_o asserted).
REQ-026 Slave read latency ≥1 cycle after acceptance; no upper bound, WAIT_RD waits indefinitely.
REQ-027 Latency: request in IDLE reaches s_avalid_o exactly 1 cycle later; minimum write occupancy 2 cycles, minimum read 3 cycles.
REQ-028 Requests arriving during GRANT/WAIT_RD SHALL wait; a master holding m_avalid_i is served within N_MASTERS arbitration rounds.
REQ-029 One outstanding transaction at most; no pipelining across masters.

Reset
REQ-030 On rst_i: state=IDLE, grant=0, last_grant=N_MASTERS-1 (master 0 wins first); all outputs 0 except m_rdata_o=s_rdata_i.
REQ-031 Reset mid-read: in-flight response discarded per REQ-025; rst_i takes priority over cke_i.

Structure
REQ-032 State encodings and N_MASTERS index-width (clog2) helper SHALL live in the shared iob_ext_mem_arbiter include header.
REQ-033 Round-robin priority selection SHALL be sub-module iob_rr_prio (inputs request vector, last pointer; output one-hot winner, index).
REQ-034 Output muxing SHALL be driven from registered grant index only.

Verification
REQ-035 Reset release, m_avalid_i=2'b11 both reads -> master 0 served first, master 1 next; grant_o 01 then 10.
REQ-036 Master 1 write addr 0x100, wstrb 0xF, s_ready_i=1 -> s_avalid_o one cycle after request, m_ready_o=2'b10, back to IDLE next cycle.
REQ-037 Read with s_rvalid_i delayed 5 cycles, rdata 0xDEADBEEF -> busy_o high throughout, m_rvalid_o=2'b01 only on rvalid cycle, data matches.
REQ-038 Both masters continuously requesting 10 transactions each -> strict alternation 0,1,0,1..., no starvation.
REQ-039 rst_i asserted in WAIT_RD, s_rvalid_i arrives after -> no m_rvalid_o, state IDLE, next grant to master 0.
REQ-040 cke_i low for 3 cycles in GRANT with s_ready_i=0 -> state, grant and last_grant unchanged.
